// File: rtl/wgt_buf_writer.sv
// Weight buffer write-side address generator: takes filter-major weights on a valid/ready
// stream and writes each into the tiled SRAM layout read back by the weight address controller.
module wgt_buf_writer #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned KERNEL_SIZE   = 1,
  parameter int unsigned NO_CHANNEL    = 3,
  parameter int unsigned NO_FILTER     = 19,
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned Rows       = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam int unsigned Total      = Rows * NO_FILTER;
  localparam int unsigned TileStride = Rows * SYSTOLIC_SIZE;
  localparam int unsigned LastF      = NO_FILTER - 1;
  localparam int unsigned MaxAddr    = (LastF / SYSTOLIC_SIZE) * TileStride
                                       + (Rows - 1) * SYSTOLIC_SIZE + (LastF % SYSTOLIC_SIZE);
  localparam int unsigned AddrSpace  = 1 << ADDR_WIDTH;

  localparam int unsigned RowW  = $clog2(Rows > 1 ? Rows : 2);
  localparam int unsigned LaneW = $clog2(SYSTOLIC_SIZE > 1 ? SYSTOLIC_SIZE : 2);
  localparam int unsigned CntW  = $clog2(Total > 1 ? Total : 2);

  localparam logic [ADDR_WIDTH-1:0] AddrStep   = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [ADDR_WIDTH-1:0] AddrTile   = ADDR_WIDTH'(TileStride);
  localparam logic [ADDR_WIDTH-1:0] AddrOne    = ADDR_WIDTH'(1);
  localparam logic [RowW-1:0]       RowLast    = RowW'(Rows - 1);
  localparam logic [LaneW-1:0]      LaneLast   = LaneW'(SYSTOLIC_SIZE - 1);
  localparam logic [CntW-1:0]       CntLast    = CntW'(Total - 1);

  if (MaxAddr >= AddrSpace) begin : g_addr_overflow
    $error("wgt_buf_writer: max address %0d does not fit in %0d bits", MaxAddr, ADDR_WIDTH);
  end

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [LaneW-1:0]      lane_q, lane_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] tile_base_q, tile_base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  xfer;

  assign in_ready = (state_q == StLoad);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    tile_base_d = tile_base_q;
    addr_d      = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          row_d       = '0;
          lane_d      = '0;
          cnt_d       = '0;
          tile_base_d = '0;
          addr_d      = '0;
        end
      end
      StLoad: begin
        if (xfer) begin
          cnt_d = cnt_q + CntW'(1);
          if (row_q != RowLast) begin
            row_d  = row_q + RowW'(1);
            addr_d = addr_q + AddrStep;
          end else if (lane_q != LaneLast) begin
            // Next filter in the same tile starts one lane over from the tile base.
            row_d  = '0;
            lane_d = lane_q + LaneW'(1);
            addr_d = tile_base_q + ADDR_WIDTH'(lane_q) + AddrOne;
          end else begin
            row_d       = '0;
            lane_d      = '0;
            tile_base_d = tile_base_q + AddrTile;
            addr_d      = tile_base_q + AddrTile;
          end
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      tile_base_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      tile_base_q <= tile_base_d;
      addr_q      <= addr_d;
    end
  end

  // Write port and status are registered; done trails the DONE state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= addr_q;
        wr_data <= in_data;
      end
      done <= (state_q == StDone);
      if (state_q == StIdle && start) begin
        busy <= 1'b1;
      end else if (state_q == StDone) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wgt_buf_writer.sv
// Directed bench for wgt_buf_writer: default layer (19 filters, R=3) and a 3x3x2x16 layer.
module tb_wgt_buf_writer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a, in_valid_a, in_ready_a, wr_en_a, busy_a, done_a;
  logic [15:0] in_data_a, wr_data_a;
  logic [10:0] wr_addr_a;

  logic        start_b, in_valid_b, in_ready_b, wr_en_b, busy_b, done_b;
  logic [15:0] in_data_b, wr_data_b;
  logic [10:0] wr_addr_b;

  wgt_buf_writer u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .in_data  (in_data_a),
    .in_valid (in_valid_a),
    .in_ready (in_ready_a),
    .wr_en    (wr_en_a),
    .wr_addr  (wr_addr_a),
    .wr_data  (wr_data_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  wgt_buf_writer #(
    .KERNEL_SIZE (3),
    .NO_CHANNEL  (2),
    .NO_FILTER   (16)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .in_data  (in_data_b),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_data  (wr_data_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  int checks = 0;
  int errors = 0;
  int qa_addr[$];
  int qa_data[$];
  int qb_addr[$];
  bit mon_a  = 1'b0;
  bit pend_a = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int k, input int rows, input int s);
    int f = k / rows;
    int r = k % rows;
    return (f / s) * rows * s + r * s + (f % s);
  endfunction

  function automatic logic [15:0] word_val(input int k);
    return 16'(k * 37 + 'h1200);
  endfunction

  // A write must appear exactly in the cycle after each accepted transfer.
  always @(negedge clk) begin
    if (mon_a) check("wr_en_follows_xfer", int'(wr_en_a), int'(pend_a));
    if (wr_en_a) begin
      qa_addr.push_back(int'(wr_addr_a));
      qa_data.push_back(int'(wr_data_a));
    end
    pend_a = in_valid_a && in_ready_a && !rst;
  end

  always @(negedge clk) begin
    if (wr_en_b) qb_addr.push_back(int'(wr_addr_b));
  end

  task automatic start_layer_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("busy_after_start", int'(busy_a), 1);
    check("in_ready_after_start", int'(in_ready_a), 1);
  endtask

  // Offers words 0..n-1; returns in the cycle of the final transfer.
  task automatic load_a(input bit gaps, input int n, input int mid_start);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
      in_valid_a = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start_a    = (idx == mid_start);
      in_data_a  = word_val(idx);
      if (in_valid_a && in_ready_a) idx++;
    end
    check("load_progress", idx, n);
  endtask

  task automatic finish_a();
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    start_a    = 1'b0;
    check("in_ready_fall", int'(in_ready_a), 0);
    check("wr_en_last", int'(wr_en_a), 1);
    check("done_not_early", int'(done_a), 0);
    check("busy_hold", int'(busy_a), 1);
    @(posedge clk); #1;
    check("done_pulse", int'(done_a), 1);
    check("busy_fall", int'(busy_a), 0);
    check("wr_en_after_last", int'(wr_en_a), 0);
    @(posedge clk); #1;
    check("done_width", int'(done_a), 0);
  endtask

  task automatic check_layer_a(input string tag);
    check({tag, "_count"}, qa_addr.size(), 57);
    for (int k = 0; k < qa_addr.size() && k < 57; k++) begin
      check($sformatf("%s_addr%0d", tag, k), qa_addr[k], exp_addr(k, 3, 16));
      check($sformatf("%s_data%0d", tag, k), qa_data[k], int'(word_val(k)));
    end
    if (qa_addr.size() >= 57) begin
      check({tag, "_first"}, qa_addr[0], 0);
      check({tag, "_f1_r0"}, qa_addr[3], 1);
      check({tag, "_f15_r2"}, qa_addr[47], 47);
      check({tag, "_f16_r0"}, qa_addr[48], 48);
      check({tag, "_last"}, qa_addr[56], 82);
    end
    qa_addr.delete();
    qa_data.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start_a    = 1'b0;
    in_valid_a = 1'b0;
    in_data_a  = '0;
    start_b    = 1'b0;
    in_valid_b = 1'b0;
    in_data_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready_a), 0);
    check("rst_wr_en", int'(wr_en_a), 0);
    check("rst_wr_addr", int'(wr_addr_a), 0);
    check("rst_wr_data", int'(wr_data_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    mon_a = 1'b1;

    // Full layer, in_valid held high.
    start_layer_a();
    load_a(1'b0, 57, -1);
    finish_a();
    check_layer_a("steady");

    // Back-to-back layer with random gaps and a stray start in mid-load.
    start_layer_a();
    load_a(1'b1, 57, 10);
    finish_a();
    check_layer_a("gappy");

    // Reset after word 20, with start held during reset.
    mon_a = 1'b0;
    start_layer_a();
    load_a(1'b0, 21, -1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready_a), 0);
    check("midrst_wr_en", int'(wr_en_a), 0);
    check("midrst_wr_addr", int'(wr_addr_a), 0);
    check("midrst_wr_data", int'(wr_data_a), 0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_done", int'(done_a), 0);
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("postrst_in_ready", int'(in_ready_a), 0);
      check("postrst_busy", int'(busy_a), 0);
      check("postrst_wr_en", int'(wr_en_a), 0);
    end
    in_valid_a = 1'b0;
    check("partial_count", qa_addr.size(), 21);
    if (qa_addr.size() == 21) check("partial_last_addr", qa_addr[20], 38);
    qa_addr.delete();
    qa_data.delete();
    @(negedge clk);
    mon_a = 1'b1;

    // 3x3 kernel, 2 channels, 16 filters: one full tile of 288 words.
    begin
      int idx = 0;
      int guard = 0;
      @(posedge clk); #1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b    = 1'b0;
      in_valid_b = 1'b1;
      while (idx < 288 && guard < 1000) begin
        in_data_b = word_val(idx);
        @(posedge clk); #1;
        guard++;
        if (in_ready_b || idx == 287) idx++;
      end
      check("b_load_progress", idx, 288);
      in_valid_b = 1'b0;
      check("b_in_ready_fall", int'(in_ready_b), 0);
      @(posedge clk); #1;
      check("b_done_pulse", int'(done_b), 1);
      check("b_busy_fall", int'(busy_b), 0);
      check("b_count", qb_addr.size(), 288);
      for (int k = 0; k < qb_addr.size() && k < 288; k++) begin
        check($sformatf("b_addr%0d", k), qb_addr[k], exp_addr(k, 18, 16));
      end
      if (qb_addr.size() == 288) begin
        check("b_f0_r1", qb_addr[1], 16);
        check("b_f0_r17", qb_addr[17], 272);
        check("b_last", qb_addr[287], 287);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
